cache_fill_ctrl: RTL and testbench

Line-fill and write-port controller for the two-port 256-bit cache RAM. On a miss it fetches a 32-byte line from the memory bus as an 8-beat critical-word-first wrapping burst. It forwards the critical word to the core, assembles the line, and writes it through the RAM write port. It also arbitrates that single write port between line fills and core store-hit line writes.

---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_fill_ctrl_if.sv | 44 ++++
 rtl/cache_fill_ctrl_line_buf.sv | 38 +++
 rtl/cache_fill_ctrl.sv | 160 ++++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache line-fill controller.
package cache_pkg;

  localparam int NL     = 256;
  localparam int LSS    = 8;
  localparam int LINE_W = 256;
  localparam int WORD_W = 32;
  localparam int WPL    = 8;
  localparam int WSEL_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FILL  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  // Word slot for burst beat k: the burst starts at the critical word and wraps in the line.
  function automatic logic [WSEL_W-1:0] wrap_slot(input logic [WSEL_W-1:0] crit_w,
                                                  input logic [WSEL_W-1:0] beat);
    return crit_w + beat;
  endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Core-miss, memory-burst, store and RAM-write signals of the fill controller.
interface cache_fill_ctrl_if;

  logic                         miss_req;
  logic [31:0]                  miss_addr;
  logic                         miss_busy;
  logic [31:0]                  crit_data;
  logic                         crit_vld;
  logic                         fill_done;
  logic                         fill_err;

  logic                         mem_req;
  logic [31:0]                  mem_addr;
  logic                         mem_gnt;
  logic                         mem_valid;
  logic [31:0]                  mem_data;
  logic                         mem_err;

  logic                         st_req;
  logic [cache_pkg::LSS-1:0]    st_sel;
  logic [cache_pkg::LINE_W-1:0] st_line;
  logic                         st_stall;

  logic [cache_pkg::LSS-1:0]    wr_sel;
  logic [cache_pkg::LINE_W-1:0] wr_line;
  logic                         wr_ena;

  // Controller side.
  modport master (
    input  miss_req, miss_addr, mem_gnt, mem_valid, mem_data, mem_err,
           st_req, st_sel, st_line,
    output miss_busy, crit_data, crit_vld, fill_done, fill_err,
           mem_req, mem_addr, st_stall, wr_sel, wr_line, wr_ena
  );

  // Core / memory / RAM side.
  modport slave (
    output miss_req, miss_addr, mem_gnt, mem_valid, mem_data, mem_err,
           st_req, st_sel, st_line,
    input  miss_busy, crit_data, crit_vld, fill_done, fill_err,
           mem_req, mem_addr, st_stall, wr_sel, wr_line, wr_ena
  );

endinterface

// File: rtl/cache_fill_ctrl_line_buf.sv
// Line assembly buffer: one 256-bit register written a word at a time.
// line_o shows the line including any word written this cycle, so the
// last beat can go straight into the RAM write register.
module fill_line_buf
  import cache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [WSEL_W-1:0] wsel_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [LINE_W-1:0] line_o
);

  logic [LINE_W-1:0] line_q, line_d;

  // Next line value: clear wins, otherwise merge the selected word.
  always_comb begin
    line_d = line_q;
    if (clr_i) begin
      line_d = '0;
    end else if (we_i) begin
      for (int j = 0; j < WPL; j++) begin
        if (wsel_i == j[WSEL_W-1:0]) line_d[j*WORD_W +: WORD_W] = wdata_i;
      end
    end
  end

  // Line register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) line_q <= '0;
    else          line_q <= line_d;
  end

  assign line_o = line_d;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Line-fill controller: critical-word-first burst fetch, line assembly and
// arbitration of the single RAM write port between fills and store hits.
//
// state | meaning
// IDLE  | waiting for a miss
// REQ   | burst request on the memory bus, waiting for grant
// FILL  | collecting the 8 wrapping beats
// WRITE | filled line on the RAM write port
// DONE  | fill_done pulse
// ERR   | fill_err pulse, line discarded
module cache_fill_ctrl
  import cache_pkg::*;
(
  input logic               nGCLK,
  input logic               nRESET,
  cache_fill_ctrl_if.master bus
);

  state_e              state_q, state_d;
  logic [LSS-1:0]      fill_idx_q, fill_idx_d;
  logic [WSEL_W-1:0]   crit_w_q, crit_w_d;
  logic [WSEL_W-1:0]   beat_q, beat_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   crit_data_q, crit_data_d;
  logic                crit_vld_d;
  logic                mem_req_q, crit_vld_q, fill_done_q, fill_err_q, miss_busy_q;
  logic                wr_ena_q, wr_ena_d;
  logic [LSS-1:0]      wr_sel_q, wr_sel_d;
  logic [LINE_W-1:0]   wr_line_q, wr_line_d;
  logic                buf_clr, buf_we;
  logic [LINE_W-1:0]   buf_line;
  logic                last_beat, fill_wr, st_stall, st_acc;

  fill_line_buf u_buf (
    .clk_i   (nGCLK),
    .rst_n_i (nRESET),
    .clr_i   (buf_clr),
    .we_i    (buf_we),
    .wsel_i  (wrap_slot(crit_w_q, beat_q)),
    .wdata_i (bus.mem_data),
    .line_o  (buf_line)
  );

  // Next-state, beat counting and buffer control.
  always_comb begin
    state_d     = state_q;
    fill_idx_d  = fill_idx_q;
    crit_w_d    = crit_w_q;
    beat_d      = beat_q;
    mem_addr_d  = mem_addr_q;
    crit_data_d = crit_data_q;
    crit_vld_d  = 1'b0;
    buf_clr     = 1'b0;
    buf_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.miss_req) begin
          mem_addr_d = bus.miss_addr & 32'hFFFF_FFFC;
          fill_idx_d = bus.miss_addr[LSS+4:5];
          crit_w_d   = bus.miss_addr[4:2];
          beat_d     = '0;
          buf_clr    = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus.mem_gnt) state_d = FILL;
      end
      FILL: begin
        if (bus.mem_valid) begin
          if (bus.mem_err) begin
            buf_clr = 1'b1;
            state_d = ERR;
          end else begin
            buf_we = 1'b1;
            beat_d = beat_q + 3'd1;
            if (beat_q == 3'd0) begin
              crit_vld_d  = 1'b1;
              crit_data_d = bus.mem_data;
            end
            if (beat_q == 3'd7) state_d = WRITE;
          end
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write-port arbitration: a store never shares a cycle with the fill write.
  always_comb begin
    last_beat = (state_q == FILL) && bus.mem_valid && (beat_q == 3'd7);
    fill_wr   = last_beat && !bus.mem_err;
    st_stall  = bus.st_req &&
                (((state_q == FILL) && ((bus.st_sel == fill_idx_q) || last_beat)) ||
                 (state_q == WRITE));
    st_acc    = bus.st_req && !st_stall;
    wr_ena_d  = fill_wr || st_acc;
    wr_sel_d  = wr_sel_q;
    wr_line_d = wr_line_q;
    if (fill_wr) begin
      wr_sel_d  = fill_idx_q;
      wr_line_d = buf_line;
    end else if (st_acc) begin
      wr_sel_d  = bus.st_sel;
      wr_line_d = bus.st_line;
    end
  end

  // State and registered outputs.
  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      fill_idx_q  <= '0;
      crit_w_q    <= '0;
      beat_q      <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      crit_data_q <= '0;
      crit_vld_q  <= 1'b0;
      fill_done_q <= 1'b0;
      fill_err_q  <= 1'b0;
      miss_busy_q <= 1'b0;
      wr_ena_q    <= 1'b0;
      wr_sel_q    <= '0;
      wr_line_q   <= '0;
    end else begin
      state_q     <= state_d;
      fill_idx_q  <= fill_idx_d;
      crit_w_q    <= crit_w_d;
      beat_q      <= beat_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= (state_d == REQ);
      crit_data_q <= crit_data_d;
      crit_vld_q  <= crit_vld_d;
      fill_done_q <= (state_d == DONE);
      fill_err_q  <= (state_d == ERR);
      // Busy drops together with the done/err pulse.
      miss_busy_q <= (state_d == REQ) || (state_d == FILL) || (state_d == WRITE);
      wr_ena_q    <= wr_ena_d;
      wr_sel_q    <= wr_sel_d;
      wr_line_q   <= wr_line_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.crit_data = crit_data_q;
  assign bus.crit_vld  = crit_vld_q;
  assign bus.fill_done = fill_done_q;
  assign bus.fill_err  = fill_err_q;
  assign bus.miss_busy = miss_busy_q;
  assign bus.st_stall  = st_stall;
  assign bus.wr_ena    = wr_ena_q;
  assign bus.wr_sel    = wr_sel_q;
  assign bus.wr_line   = wr_line_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: directed test-plan fills plus randomized fills,
// checked against a word-slot line model and a RAM content model.
module tb_cache_fill_ctrl;

  logic clk, rst_n;
  cache_fill_ctrl_if bus();

  cache_fill_ctrl dut (
    .nGCLK  (clk),
    .nRESET (rst_n),
    .bus    (bus)
  );

  typedef struct {
    int           c;
    logic [7:0]   sel;
    logic [255:0] line;
  } wr_t;

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  wr_t          wq[$];
  logic [255:0] ram[int];
  logic [255:0] exp_ram[int];
  logic         last_stall;
  bit           acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: captures every write-port cycle seen mid-cycle.
  always @(negedge clk) begin
    wr_t w;
    if (bus.wr_ena === 1'b1) begin
      w.c = cyc; w.sel = bus.wr_sel; w.line = bus.wr_line;
      wq.push_back(w);
      ram[int'(bus.wr_sel)] = bus.wr_line;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample stall/acceptance mid-cycle, return just after the next edge.
  task automatic tick();
    @(negedge clk);
    last_stall = bus.st_stall;
    acc = bus.st_req && !bus.st_stall;
    @(posedge clk);
    #1;
    if (acc) bus.st_req = 1'b0;
  endtask

  task automatic do_fill(input logic [31:0] addr, input int base, input int gap_at,
                         input int gap_n, input int err_at, input int st_at,
                         input logic [7:0] ssel, input logic [255:0] sline);
    logic [31:0]  beats[8];
    logic [255:0] exp_line;
    int           crit, idx, n0, miss_cyc, b7_cyc, st_cyc, st_wcyc, guard, gaps;
    bit           exp_stall, found;
    crit = int'(addr[4:2]);
    idx  = int'(addr[12:5]);
    gaps = (gap_at >= 0 && gap_at < 8) ? gap_n : 0;
    exp_line = '0;
    exp_stall = 1'b0;
    st_cyc = -1;
    b7_cyc = -1;
    for (int k = 0; k < 8; k++) begin
      beats[k] = (base < 0) ? $urandom : 32'(base + k);
      exp_line[32*((crit + k) % 8) +: 32] = beats[k];
    end
    n0 = wq.size();
    bus.miss_addr = addr;
    bus.miss_req  = 1'b1;
    miss_cyc = cyc;
    tick();
    bus.miss_req = 1'b0;
    check("mem_req_rise", bus.mem_req, 1);
    check("busy_rise", bus.miss_busy, 1);
    check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    check("mem_req_drop", bus.mem_req, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == gap_at) repeat (gap_n) tick();
      bus.mem_valid = 1'b1;
      bus.mem_data  = beats[k];
      bus.mem_err   = (k == err_at);
      if (k == st_at) begin
        bus.st_req = 1'b1; bus.st_sel = ssel; bus.st_line = sline; st_cyc = cyc;
      end
      if (k == 7) b7_cyc = cyc;
      tick();
      bus.mem_valid = 1'b0;
      bus.mem_err   = 1'b0;
      if (k == st_at) begin
        exp_stall = (int'(ssel) == idx) || (k == 7);
        check("st_stall", last_stall, exp_stall);
      end
      if (k == err_at) begin
        check("fill_err", bus.fill_err, 1);
        check("busy_after_err", bus.miss_busy, 0);
        tick();
        check("fill_err_pulse", bus.fill_err, 0);
        check("no_write_on_err", wq.size(), n0);
        return;
      end
      if (k == 0) begin
        check("crit_vld", bus.crit_vld, 1);
        check("crit_data", bus.crit_data, beats[0]);
      end
    end
    check("fill_wr_ena", bus.wr_ena, 1);
    check("fill_wr_sel", bus.wr_sel, idx);
    check("fill_wr_line", bus.wr_line, exp_line);
    tick();
    check("fill_done", bus.fill_done, 1);
    check("busy_fall", bus.miss_busy, 0);
    check("no_wr_in_done", bus.wr_ena, 0);
    check("latency", cyc - miss_cyc, 11 + gaps);
    tick();
    check("fill_done_pulse", bus.fill_done, 0);
    exp_ram[idx] = exp_line;
    if (st_at >= 0) begin
      guard = 0;
      while (bus.st_req && guard < 10) begin tick(); guard++; end
      check("st_accepted", bus.st_req, 0);
      tick();
      exp_ram[int'(ssel)] = sline;
      st_wcyc = exp_stall ? b7_cyc + 3 : st_cyc + 1;
      found = 1'b0;
      for (int i = n0; i < wq.size(); i++)
        if (wq[i].c == st_wcyc && wq[i].sel == ssel && wq[i].line == sline) found = 1'b1;
      check("st_write_cycle", found, 1);
    end
    found = 1'b0;
    for (int i = n0; i < wq.size(); i++)
      if (wq[i].c == b7_cyc + 1 && int'(wq[i].sel) == idx && wq[i].line == exp_line) found = 1'b1;
    check("fill_write_cycle", found, 1);
    if (!ram.exists(idx)) check("ram_written", 0, 1);
    else                  check("ram_line", ram[idx], exp_ram[idx]);
  endtask

  initial begin
    logic [255:0] l;
    int           n0, gap_at, gap_n, err_at, st_at;
    logic [31:0]  addr;
    logic [7:0]   ssel;
    logic [255:0] sline;

    rst_n = 1'b0;
    bus.miss_req = 0; bus.miss_addr = '0; bus.mem_gnt = 0; bus.mem_valid = 0;
    bus.mem_data = '0; bus.mem_err = 0; bus.st_req = 0; bus.st_sel = '0; bus.st_line = '0;
    #12;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_busy", bus.miss_busy, 0);
    check("rst_wr_ena", bus.wr_ena, 0);
    check("rst_wr_line", bus.wr_line, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.st_req = 1'b1;
    #1 check("idle_no_stall", bus.st_stall, 0);
    bus.st_req = 1'b0;

    do_fill(32'h0000_1234, 'hA0, -1, 0, -1, -1, 8'h00, '0);
    l = ram.exists(32'h91) ? ram[32'h91] : '0;
    check("plan_word5", l[5*32 +: 32], 32'hA0);
    check("plan_word0", l[0 +: 32], 32'hA3);
    check("plan_word4", l[4*32 +: 32], 32'hA7);

    do_fill(32'h0000_1234, 'hA0, 4, 3, -1, -1, 8'h00, '0);
    do_fill(32'h0000_2468, 'hB0, -1, 0, 4, -1, 8'h00, '0);
    do_fill(32'h0000_020C, -1, -1, 0, -1, 1, 8'h10, {8{32'h5A5A_0010}});
    do_fill(32'h0000_020C, -1, -1, 0, -1, 2, 8'h22, {8{32'h5A5A_0022}});
    do_fill(32'h0000_0A04, -1, -1, 0, -1, 7, 8'h33, {8{32'h5A5A_0033}});

    // Reset in the middle of a fill, after beat 2.
    n0 = wq.size();
    bus.miss_addr = 32'h0004_0ABC; bus.miss_req = 1'b1; tick(); bus.miss_req = 1'b0;
    bus.mem_gnt = 1'b1; tick(); bus.mem_gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_valid = 1'b1; bus.mem_data = 32'hC0 + k; tick();
    end
    bus.mem_valid = 1'b0;
    bus.st_req = 1'b1; bus.st_sel = 8'h05;
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req", bus.mem_req, 0);
    check("arst_mem_addr", bus.mem_addr, 0);
    check("arst_busy", bus.miss_busy, 0);
    check("arst_crit", {bus.crit_vld, bus.crit_data}, 0);
    check("arst_pulses", {bus.fill_done, bus.fill_err}, 0);
    check("arst_wr", {bus.wr_ena, bus.wr_sel, bus.wr_line}, 0);
    check("arst_stall", bus.st_stall, 0);
    bus.st_req = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    tick(); tick();
    check("arst_no_write", wq.size(), n0);
    do_fill(32'h0004_0ABC, -1, -1, 0, -1, -1, 8'h00, '0);

    for (int it = 0; it < 10; it++) begin
      addr   = $urandom;
      gap_at = $urandom_range(0, 8);
      gap_n  = $urandom_range(0, 3);
      err_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1;
      st_at  = (err_at < 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : -1;
      ssel   = ($urandom_range(0, 2) == 0) ? addr[12:5] : 8'($urandom);
      for (int j = 0; j < 8; j++) sline[j*32 +: 32] = $urandom;
      do_fill(addr, -1, gap_at, gap_n, err_at, st_at, ssel, sline);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
